// File: rtl/reg_share_arb.sv
// Round-robin write arbiter owning a shared WIDTH-bit register.
// Owners hand off through a one-cycle idle gap; a hold limit rotates ownership under contention.
module reg_share_arb #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       r,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WIDTH-1:0]     wdata,
   output logic [N_REQ-1:0]           gnt,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic [WIDTH-1:0]           q,
   output logic                       busy,
   output logic                       loaded
);

   localparam int unsigned PW = $clog2(N_REQ);
   localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [PW-1:0]     ptr, ptr_n;
   logic [HW-1:0]     hold_cnt, hold_n;
   logic [N_REQ-1:0]  gnt_n;
   logic [PW-1:0]     owner_n;
   logic [WIDTH-1:0]  q_n;
   logic              busy_n, loaded_n;

   logic [PW-1:0]     winner;
   logic [PW-1:0]     idx;
   logic              hit;
   logic              others;
   logic              drop;
   logic [WIDTH-1:0]  slice [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign slice[i] = wdata[i*WIDTH +: WIDTH];
   end

   // First requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      winner = ptr;
      idx    = ptr;
      hit    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + PW'(k);
         if (!hit && req[idx]) begin
            winner = idx;
            hit    = 1'b1;
         end
      end
   end

   assign others = |(req & ~(N_REQ'(1) << owner));

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      hold_n   = hold_cnt;
      gnt_n    = gnt;
      owner_n  = owner;
      q_n      = q;
      busy_n   = busy;
      loaded_n = 1'b0;
      drop     = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = GRANT;
               owner_n = winner;
               gnt_n   = N_REQ'(1) << winner;
               hold_n  = '0;
               busy_n  = 1'b1;
            end
         end
         GRANT: begin
            if (req[owner]) begin
               q_n      = slice[owner];
               loaded_n = 1'b1;
               if (hold_cnt == HOLD_LAST) begin
                  drop = others;
               end else begin
                  hold_n = hold_cnt + HW'(1);
               end
            end else begin
               drop = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Release or preemption: rotate pointer past the outgoing owner.
      if (drop) begin
         state_n = IDLE;
         gnt_n   = '0;
         busy_n  = 1'b0;
         hold_n  = '0;
         ptr_n   = owner + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         owner    <= '0;
         q        <= '0;
         busy     <= 1'b0;
         loaded   <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         gnt      <= gnt_n;
         owner    <= owner_n;
         q        <= q_n;
         busy     <= busy_n;
         loaded   <= loaded_n;
      end
   end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop register with asynchronous reset. N_REQ requesters compete for write ownership through a registered req/gnt handshake. The owner's data loads into the register on every owned cycle. A hold limit forces fair rotation when other requesters are waiting. The block sits between requesting datapath units and the shared register and owns that register.

## Interface
- N_REQ, 4: number of requesters; power of two, 2..8.
- WIDTH, 8: register width in bits.
- MAX_HOLD, 4: maximum loads per grant when another requester is pending; must be ≥1.
- clk  input  1  clock; all state changes on its rising edge.
- r  input  1  reset; asynchronous, active-high.
- req  input  N_REQ  request per requester; held high while the requester wants ownership.
- wdata  input  N_REQ*WIDTH  packed write data; slice i is [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- owner  output  log2(N_REQ)  index of the current or last owner.
- q  output  WIDTH  shared register contents.
- busy  output  1  high while in GRANT.
- loaded  output  1  one-cycle pulse after each edge that wrote q.

## Operation
- States:
  - IDLE (gnt=0, busy=0).
  - GRANT (gnt=onehot(owner), busy=1).
- Round-robin pointer ptr (log2(N_REQ) bits):
  - The winner is the first i with req[i]=1, searching ptr, ptr+1, … modulo N_REQ.
- IDLE, req≠0 at an edge:
  - go to GRANT; owner←winner; gnt←onehot(winner); hold_cnt←0.
  - No load occurs on this edge.
- IDLE, req=0: stay; q holds.
- GRANT, edge with req[owner]=1:
  - q←wdata slice owner; loaded←1.
  - hold_cnt←min(hold_cnt+1, MAX_HOLD−1).
- GRANT, edge with req[owner]=0:
  - no load; loaded←0.
  - go to IDLE; gnt←0; ptr←owner+1 (mod N_REQ, wraps N_REQ−1→0).
- Preemption: at a GRANT edge with req[owner]=1, hold_cnt=MAX_HOLD−1, and any other req bit set:
  - the load still happens.
  - then go to IDLE; gnt←0; ptr←owner+1.
- No other requester pending: the owner keeps the grant indefinitely; hold_cnt saturates.
- Requests are ignored except through the IDLE winner selection and the owner's own bit.
  - A non-owner request never loads q.
- loaded is 0 on every edge that does not write q.
- q is written only by the owner in GRANT; it holds its value in IDLE and across owner changes.

## Timing
- Async reset (r=1), effective immediately with no clock needed:
  - state=IDLE, gnt=0, owner=0, ptr=0, hold_cnt=0, q=0, busy=0, loaded=0.
- Reset applied mid-GRANT drops gnt and clears q at once.
- After r falls, the first edge behaves as an IDLE edge.
- Grant latency: req sampled at edge E0 → gnt high after E0 → first q load at E1.
  - q shows the new data and loaded=1 after E1.
- Turnaround: every owner change passes through at least one full IDLE cycle with gnt=0.
  - Release/preempt at Ek → next grant at Ek+1 at the earliest.
- Under continuous contention, each owner gets exactly MAX_HOLD loads per tenure, then 1 idle cycle.
- gnt, owner, busy, loaded and q are register outputs; there is no combinational path from req to gnt.

## Test plan
- Reset: assert r=1 asynchronously mid-cycle → q=0x00, gnt=4'b0000, busy=0, loaded=0 without a clock edge.
- Single requester:
  - stimulus: req=4'b0010, wdata slice1=0xA5.
  - response: after edge 1 gnt=4'b0010, owner=1, q=0x00; after edge 2 q=0xA5, loaded=1.
  - then drop req: gnt=0 after next edge, q stays 0xA5, loaded=0.
- Full contention:
  - stimulus: req=4'b1111 held from reset, slice i=0x10+i, MAX_HOLD=4.
  - response: grants in order 0,1,2,3,0; each gnt lasts 4 edges (4 loads), separated by one idle cycle.
  - q steps 0x10→0x11→0x12→0x13.
- Uncontended hold: only req0 held for 10 cycles → gnt=4'b0001 throughout, 10 consecutive loaded pulses after the first load edge, no preemption.
- Pointer wrap:
  - stimulus: req=4'b1001 after owner 3 releases.
  - response: ptr=0, next grant to 0, then 3 after preemption/release.
  - owner 3 then wraps ptr to 0.
- Reset mid-grant:
  - stimulus: owner 2 granted with q=0x5C; pulse r between edges.
  - response: gnt=0, q=0 immediately; with req=4'b0110 afterwards, the next grant goes to 1 (ptr reset to 0).
